// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - writeback, read, reserve and flush signals of the register file
interface register_file_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  destinationEnable;
  logic [4:0]            writeAddress;
  logic [DATA_WIDTH-1:0] writeData;
  logic [4:0]            readAddressA;
  logic [4:0]            readAddressB;
  logic [DATA_WIDTH-1:0] readDataA;
  logic [DATA_WIDTH-1:0] readDataB;
  logic                  pendingA;
  logic                  pendingB;
  logic                  reserveEnable;
  logic [4:0]            reserveAddress;
  logic                  reserveReady;
  logic                  flush;

  modport master (
    output destinationEnable, writeAddress, writeData,
    output readAddressA, readAddressB,
    output reserveEnable, reserveAddress, flush,
    input  readDataA, readDataB, pendingA, pendingB, reserveReady
  );

  modport slave (
    input  destinationEnable, writeAddress, writeData,
    input  readAddressA, readAddressB,
    input  reserveEnable, reserveAddress, flush,
    output readDataA, readDataB, pendingA, pendingB, reserveReady
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 31-entry integer register file with write bypass and pending-write scoreboard
module register_file #(
  parameter int DATA_WIDTH    = 32,
  parameter int PENDING_WIDTH = 2
) (
  input logic           clock,
  input logic           reset,
  register_file_if.slave bus
);
  localparam logic [PENDING_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [PENDING_WIDTH-1:0] COUNT_ONE = PENDING_WIDTH'(1);

  logic [DATA_WIDTH-1:0]    regs  [1:31];
  logic [PENDING_WIDTH-1:0] count [1:31];

  logic                     write_valid;
  logic                     release_hit;
  logic                     reserve_ready;
  logic                     reserve_accept;
  logic [PENDING_WIDTH-1:0] count_write;
  logic [PENDING_WIDTH-1:0] count_reserve;
  logic [PENDING_WIDTH-1:0] count_a;
  logic [PENDING_WIDTH-1:0] count_b;
  logic [DATA_WIDTH-1:0]    data_a;
  logic [DATA_WIDTH-1:0]    data_b;

  // x0 has no storage; every lookup of address 0 yields a zero count
  always_comb begin
    count_write   = '0;
    count_reserve = '0;
    count_a       = '0;
    count_b       = '0;
    if (bus.writeAddress   != 5'd0) count_write   = count[bus.writeAddress];
    if (bus.reserveAddress != 5'd0) count_reserve = count[bus.reserveAddress];
    if (bus.readAddressA   != 5'd0) count_a       = count[bus.readAddressA];
    if (bus.readAddressB   != 5'd0) count_b       = count[bus.readAddressB];
  end

  assign write_valid    = bus.destinationEnable && (bus.writeAddress != 5'd0);
  assign release_hit    = write_valid && (count_write != '0);
  assign reserve_ready  = !((bus.reserveAddress != 5'd0) && (count_reserve == COUNT_MAX));
  assign reserve_accept = bus.reserveEnable && reserve_ready && (bus.reserveAddress != 5'd0);

  always_comb begin
    data_a = '0;
    data_b = '0;
    if (write_valid && (bus.readAddressA == bus.writeAddress)) data_a = bus.writeData;
    else if (bus.readAddressA != 5'd0)                         data_a = regs[bus.readAddressA];
    if (write_valid && (bus.readAddressB == bus.writeAddress)) data_b = bus.writeData;
    else if (bus.readAddressB != 5'd0)                         data_b = regs[bus.readAddressB];
  end

  // The last in-flight writer retiring this cycle is covered by the bypass
  assign bus.pendingA = (count_a != '0) &&
      !(release_hit && (bus.writeAddress == bus.readAddressA) && (count_a == COUNT_ONE));
  assign bus.pendingB = (count_b != '0) &&
      !(release_hit && (bus.writeAddress == bus.readAddressB) && (count_b == COUNT_ONE));

  assign bus.readDataA    = data_a;
  assign bus.readDataB    = data_b;
  assign bus.reserveReady = reserve_ready;

  for (genvar g = 1; g < 32; g++) begin : g_reg
    localparam logic [4:0] ADDR = 5'(g);

    logic [DATA_WIDTH-1:0]    data_q;
    logic [PENDING_WIDTH-1:0] count_q;
    logic                     inc;
    logic                     dec;

    assign inc = reserve_accept && (bus.reserveAddress == ADDR);
    assign dec = release_hit && (bus.writeAddress == ADDR);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        data_q  <= '0;
        count_q <= '0;
      end else begin
        if (write_valid && (bus.writeAddress == ADDR)) data_q <= bus.writeData;
        if (bus.flush)        count_q <= '0;
        else if (inc && !dec) count_q <= count_q + COUNT_ONE;
        else if (dec && !inc) count_q <= count_q - COUNT_ONE;
      end
    end

    assign regs[g]  = data_q;
    assign count[g] = count_q;
  end
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - vector table, corner sequences and randomized model check of register_file
module tb_register_file;
  localparam int MAXC = 3;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        re;
    logic [4:0]  rsa;
    logic        fl;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        epa;
    logic        epb;
    logic        erdy;
  } vec_t;

  logic clock;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] mem [32];
  int          cnt [32];

  register_file_if #(.DATA_WIDTH(32)) bus ();

  register_file #(.DATA_WIDTH(32), .PENDING_WIDTH(2)) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic [4:0] ra,
                              logic [4:0] rb, logic re, logic [4:0] rsa, logic fl,
                              logic [31:0] ea, logic [31:0] eb, logic epa, logic epb,
                              logic erdy);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb; v.re = re; v.rsa = rsa;
    v.fl = fl; v.ea = ea; v.eb = eb; v.epa = epa; v.epb = epb; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.destinationEnable = v.we;
    bus.writeAddress      = v.wa;
    bus.writeData         = v.wd;
    bus.readAddressA      = v.ra;
    bus.readAddressB      = v.rb;
    bus.reserveEnable     = v.re;
    bus.reserveAddress    = v.rsa;
    bus.flush             = v.fl;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      cnt[i] = 0;
    end
  endtask

  function automatic logic [31:0] m_read(vec_t v, logic [4:0] a);
    if (a == 0) return '0;
    if (v.we && v.wa == a) return v.wd;
    return mem[a];
  endfunction

  function automatic logic m_pend(vec_t v, logic [4:0] a);
    if (a == 0 || cnt[a] == 0) return 1'b0;
    if (v.we && v.wa == a && cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic vec_t m_expect(vec_t v);
    vec_t e = v;
    e.ea   = m_read(v, v.ra);
    e.eb   = m_read(v, v.rb);
    e.epa  = m_pend(v, v.ra);
    e.epb  = m_pend(v, v.rb);
    e.erdy = !(v.rsa != 0 && cnt[v.rsa] == MAXC);
    return e;
  endfunction

  task automatic model_step(vec_t v);
    bit acc;
    bit rel;
    acc = v.re && v.rsa != 0 && cnt[v.rsa] < MAXC;
    rel = v.we && v.wa != 0 && cnt[v.wa] > 0;
    if (v.we && v.wa != 0) mem[v.wa] = v.wd;
    if (v.fl) begin
      for (int i = 0; i < 32; i++) cnt[i] = 0;
    end else begin
      if (acc) cnt[v.rsa] = cnt[v.rsa] + 1;
      if (rel) cnt[v.wa]  = cnt[v.wa] - 1;
    end
  endtask

  // drives at the falling edge, samples 2ns later, the model follows the rising edge
  task automatic run(vec_t v, string tag);
    @(negedge clock);
    drive(v);
    #2;
    chk({tag, " readDataA"},    bus.readDataA,    v.ea);
    chk({tag, " readDataB"},    bus.readDataB,    v.eb);
    chk({tag, " pendingA"},     32'(bus.pendingA),     32'(v.epa));
    chk({tag, " pendingB"},     32'(bus.pendingB),     32'(v.epb));
    chk({tag, " reserveReady"}, 32'(bus.reserveReady), 32'(v.erdy));
    model_step(v);
  endtask

  vec_t tbl [21];
  vec_t idle;
  vec_t r;

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 5, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1);
    tbl[2]  = mk(1, 0, 32'h12345678, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 5, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 1);
    tbl[4]  = mk(1, 7, 32'hA5A5A5A5, 5, 7, 0, 0, 0, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 3, 7, 1, 3, 0, 0, 32'hA5A5A5A5, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 3, 0, 1, 3, 0, 0, 0, 1, 0, 1);
    tbl[7]  = mk(0, 0, 0, 3, 0, 1, 3, 0, 0, 0, 1, 0, 1);
    tbl[8]  = mk(0, 0, 0, 3, 0, 1, 3, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 3, 32'd1, 3, 0, 0, 3, 0, 32'd1, 0, 1, 0, 0);
    tbl[10] = mk(1, 3, 32'd2, 3, 0, 0, 3, 0, 32'd2, 0, 1, 0, 1);
    tbl[11] = mk(1, 3, 32'd3, 3, 3, 0, 3, 0, 32'd3, 32'd3, 0, 0, 1);
    tbl[12] = mk(0, 0, 0, 3, 0, 0, 0, 0, 32'd3, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 9, 0, 1, 9, 0, 0, 0, 0, 0, 1);
    tbl[14] = mk(1, 9, 32'h99, 9, 9, 1, 9, 0, 32'h99, 32'h99, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 9, 4, 1, 4, 1, 32'h99, 0, 1, 0, 1);
    tbl[16] = mk(0, 0, 0, 9, 4, 0, 0, 0, 32'h99, 0, 0, 0, 1);
    tbl[17] = mk(1, 10, 32'hCAFE, 10, 0, 0, 0, 0, 32'hCAFE, 0, 0, 0, 1);
    tbl[18] = mk(0, 0, 0, 10, 3, 0, 0, 0, 32'hCAFE, 32'd3, 0, 0, 1);
    tbl[19] = mk(1, 12, 32'h1212, 12, 0, 1, 12, 1, 32'h1212, 0, 0, 0, 1);
    tbl[20] = mk(0, 0, 0, 12, 0, 0, 0, 0, 32'h1212, 0, 0, 0, 1);

    // write attempted while held in reset must not land
    rst_n = 1'b0;
    drive(mk(1, 5, 32'hDEADBEEF, 5, 5, 1, 5, 0, 0, 0, 0, 0, 1));
    @(negedge clock);
    drive(mk(0, 0, 0, 5, 5, 0, 5, 0, 0, 0, 0, 0, 1));
    #2;
    chk("in_reset readDataA",    bus.readDataA, 32'h0);
    chk("in_reset pendingA",     32'(bus.pendingA), 32'h0);
    chk("in_reset reserveReady", 32'(bus.reserveReady), 32'h1);
    @(negedge clock);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) run(tbl[i], $sformatf("vec%0d", i));

    // fill x6, then drop reset asynchronously mid-cycle
    for (int i = 0; i < 3; i++) run(m_expect(mk(0, 0, 0, 6, 5, 1, 6, 0, 0, 0, 0, 0, 1)), "fill6");
    @(negedge clock);
    drive(mk(0, 0, 0, 6, 5, 0, 6, 0, 0, 0, 0, 0, 1));
    #1;
    chk("pre_async pendingA",     32'(bus.pendingA), 32'h1);
    chk("pre_async reserveReady", 32'(bus.reserveReady), 32'h0);
    chk("pre_async readDataB",    bus.readDataB, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("async pendingA",     32'(bus.pendingA), 32'h0);
    chk("async reserveReady", 32'(bus.reserveReady), 32'h1);
    chk("async readDataB",    bus.readDataB, 32'h0);
    model_reset();
    @(negedge clock);
    rst_n = 1'b1;
    run(mk(1, 6, 32'h66, 6, 5, 1, 6, 0, 32'h66, 0, 0, 0, 1), "post_reset");
    run(mk(0, 0, 0, 6, 0, 0, 6, 0, 32'h66, 0, 1, 0, 1), "post_reset2");

    for (int i = 0; i < 600; i++) begin
      r.we  = 1'($urandom_range(0, 1));
      r.wa  = 5'($urandom_range(0, 7));
      r.wd  = $urandom;
      r.ra  = 5'($urandom_range(0, 7));
      r.rb  = 5'($urandom_range(0, 7));
      r.re  = ($urandom_range(0, 3) != 0);
      r.rsa = 5'($urandom_range(0, 7));
      r.fl  = ($urandom_range(0, 19) == 0);
      run(m_expect(r), $sformatf("rnd%0d", i));
    end

    drive(idle);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
